// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: channel modes and config FSM states.
package led_pkg;
  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_RIPPLE = 2'd3
  } led_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cfg_state_t;
endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its own mode/period/duty and produces a registered drive
// plus a one-cycle pulse on the cycle after its output fell.
module led_channel
  import led_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 8,
  parameter bit FIRST  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [DUTY_W-1:0] pwm_phase,
  input  logic              prev_fall,
  input  logic              wr_en,
  input  led_mode_t         wr_mode,
  input  logic [CNT_W-1:0]  wr_period,
  input  logic [DUTY_W-1:0] wr_duty,
  output logic              led,
  output logic              fall
);
  led_mode_t         mode;
  logic [CNT_W-1:0]  period;
  logic [DUTY_W-1:0] duty;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_last;
  logic              led_d1;
  logic              blink_like;
  logic              hit;

  // A zero period behaves as a period of one tick.
  assign cnt_last   = (period == '0) ? '0 : period - 1'b1;
  assign blink_like = (mode == MODE_BLINK) || (FIRST && (mode == MODE_RIPPLE));
  assign hit        = tick && (cnt == cnt_last);
  assign fall       = led_d1 & ~led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= MODE_OFF;
      period <= CNT_W'(1);
      duty   <= '0;
      cnt    <= '0;
      led    <= 1'b0;
      led_d1 <= 1'b0;
    end else begin
      led_d1 <= led;
      if (wr_en) begin
        mode   <= wr_mode;
        period <= wr_period;
        duty   <= wr_duty;
        cnt    <= '0;
        led    <= 1'b0;
      end else if (blink_like) begin
        if (tick) cnt <= hit ? '0 : cnt + 1'b1;
        if (hit)  led <= ~led;
      end else if (mode == MODE_PWM) begin
        led <= (pwm_phase < duty);
      end else if (mode == MODE_RIPPLE) begin
        if (prev_fall) led <= ~led;
      end else begin
        led <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM phase,
// a two-state config write port, and NUM_LEDS independent channels.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter  int CLK_HZ   = 16000000,
  parameter  int TICK_HZ  = 1000,
  parameter  int NUM_LEDS = 4,
  parameter  int CNT_W    = 16,
  parameter  int DUTY_W   = 8,
  localparam int CW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                pin_clk_16M,
  input  logic                pin_rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [DUTY_W-1:0]   cfg_duty,
  output logic [NUM_LEDS-1:0] pin_leds
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]     pre;
  logic              tick;
  logic [DUTY_W-1:0] pwm_phase;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge pin_clk_16M or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      pre       <= '0;
      pwm_phase <= '0;
    end else begin
      pre       <= tick ? '0 : pre + 1'b1;
      pwm_phase <= pwm_phase + 1'b1;
    end
  end

  cfg_state_t        state, state_nxt;
  logic              ready_nxt;
  logic              accept;
  logic [CW-1:0]     lat_chan;
  led_mode_t         lat_mode;
  logic [CNT_W-1:0]  lat_period;
  logic [DUTY_W-1:0] lat_duty;

  // cfg_ready is registered so it stays low through reset and rises one edge later.
  assign accept = cfg_valid && cfg_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = ST_IDLE;
    endcase
    ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge pin_clk_16M or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      state      <= ST_IDLE;
      cfg_ready  <= 1'b0;
      lat_chan   <= '0;
      lat_mode   <= MODE_OFF;
      lat_period <= '0;
      lat_duty   <= '0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= ready_nxt;
      if (accept) begin
        lat_chan   <= cfg_chan;
        lat_mode   <= led_mode_t'(cfg_mode);
        lat_period <= cfg_period;
        lat_duty   <= cfg_duty;
      end
    end
  end

  logic [NUM_LEDS-1:0] wr;
  logic [NUM_LEDS-1:0] fall;

  // Out-of-range channel numbers match no instance, so the write is dropped.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    logic pf;
    if (i == 0) begin : g_first
      assign pf = 1'b0;
    end else begin : g_rest
      assign pf = fall[i-1];
    end
    assign wr[i] = (state == ST_APPLY) && (lat_chan == CW'(i));

    led_channel #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .FIRST(i == 0)) u_ch (
      .clk       (pin_clk_16M),
      .rst_n     (pin_rst_n),
      .tick      (tick),
      .pwm_phase (pwm_phase),
      .prev_fall (pf),
      .wr_en     (wr[i]),
      .wr_mode   (lat_mode),
      .wr_period (lat_period),
      .wr_duty   (lat_duty),
      .led       (pin_leds[i]),
      .fall      (fall[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized self-checking bench for led_pattern_gen at DIV=4, 4 channels, 8-bit period, 4-bit duty.
module tb_led_pattern_gen;
  logic       clk, rst_n, cfg_valid, cfg_ready;
  logic [1:0] cfg_chan, cfg_mode;
  logic [7:0] cfg_period;
  logic [3:0] cfg_duty, leds;
  logic       v3, rdy3;
  logic [1:0] chan3;
  logic [2:0] leds3;
  int checks = 0, errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_pattern_gen #(.CLK_HZ(16), .TICK_HZ(4), .NUM_LEDS(4), .CNT_W(8), .DUTY_W(4)) u_dut (
    .pin_clk_16M(clk), .pin_rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .pin_leds(leds));

  // Three-channel copy so a channel number past the last LED can be driven.
  led_pattern_gen #(.CLK_HZ(16), .TICK_HZ(4), .NUM_LEDS(3), .CNT_W(8), .DUTY_W(4)) u_dut3 (
    .pin_clk_16M(clk), .pin_rst_n(rst_n), .cfg_valid(v3), .cfg_ready(rdy3),
    .cfg_chan(chan3), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .pin_leds(leds3));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Reference rules: a BLINK channel toggles every max(p,1) ticks of 4 clocks;
  // PWM is high duty clocks of every 16; a ripple chain counts up by one.
  function automatic int blink_half(input int p);
    return 4 * ((p == 0) ? 1 : p);
  endfunction
  function automatic int ripple_next(input int v);
    return (v + 1) % 16;
  endfunction

  task automatic cfg_write(input int ch, input int mode, input int per, input int duty);
    int n;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("cfg_ready_timeout", cfg_ready, 1);
    cfg_chan = ch[1:0]; cfg_mode = mode[1:0]; cfg_period = per[7:0]; cfg_duty = duty[3:0];
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_edge(input int idx, output int cyc);
    logic s;
    s = leds[idx];
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (leds[idx] == s && cyc < 200);
  endtask

  task automatic count_high(input int idx, output int cnt);
    cnt = 0;
    repeat (16) begin @(negedge clk); cnt += int'(leds[idx]); end
  endtask

  initial begin
    int c, a, b, d, p, n, last, acc;
    logic have;
    logic [3:0] prv, cur;
    int pers[5];
    int duts[5];

    cfg_valid = 0; cfg_chan = 0; cfg_mode = 0; cfg_period = 0; cfg_duty = 0;
    v3 = 0; chan3 = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_leds", leds, 0);
    chk("rst_ready", cfg_ready, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("tick", u_dut.tick, (k % 4 == 3));
      if (k == 1) chk("ready_first_edge", cfg_ready, 1);
    end
    chk("leds_after_rst", leds, 0);

    // Channel 3 does not exist on the 3-LED copy: accepted, then discarded.
    chan3 = 2'd3; cfg_mode = 2'd1; cfg_period = 8'd1;
    v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    acc = 0;
    repeat (30) begin @(negedge clk); acc |= int'(leds3); end
    chk("oor_leds", acc, 0);
    chk("oor_ready", rdy3, 1);

    pers = '{3, 0, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6)};
    foreach (pers[i]) begin
      p = pers[i];
      cfg_write(0, 1, p, 0);
      wait_edge(0, c); wait_edge(0, c); wait_edge(0, c);
      chk("blink_half", c, blink_half(p));
    end

    duts = '{4, 0, 15, $urandom_range(1, 14), $urandom_range(0, 15)};
    foreach (duts[i]) begin
      d = duts[i];
      cfg_write(1, 2, $urandom_range(0, 255), d);
      repeat (4) @(negedge clk);
      count_high(1, c);
      chk("pwm_high", c, d);
    end

    // Ripple channels get random periods, which they must ignore.
    cfg_write(0, 1, 1, 0);
    for (int ch = 1; ch < 4; ch++) cfg_write(ch, 3, $urandom_range(0, 255), 0);
    repeat (10) @(negedge clk);
    prv = leds; have = 1'b0; n = 0; last = 0;
    for (int t = 0; t < 300 && n < 8; t++) begin
      @(negedge clk);
      cur = leds;
      if (cur[0] != prv[0]) begin
        if (have) begin chk("ripple_inc", prv, ripple_next(last)); n++; end
        last = int'(prv); have = 1'b1;
      end
      prv = cur;
    end
    if (n < 8) chk("ripple_timeout", n, 8);
    wait_edge(3, c); wait_edge(3, a); wait_edge(3, b);
    chk("led3_half", a, 32);
    chk("led3_period", a + b, 64);

    // Back-to-back: odd cycles carry a ch0 OFF write that must be refused.
    cfg_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("b2b_ready", cfg_ready, (k % 2 == 0));
      if (k % 2 == 1) begin cfg_chan = 2'd0; cfg_mode = 2'd0; cfg_duty = 4'd0; end
      else begin
        cfg_chan = (k == 2) ? 2'd3 : 2'd2;
        cfg_mode = (k == 4) ? 2'd0 : 2'd2;
        cfg_duty = 4'd15;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    count_high(3, c); chk("b2b_ch3", c, 15);
    count_high(2, c); chk("b2b_ch2", c, 0);
    wait_edge(0, c); wait_edge(0, c);
    chk("b2b_ch0_alive", c, blink_half(1));

    // Reset lands while the write to ch2 sits in APPLY.
    cfg_chan = 2'd2; cfg_mode = 2'd1; cfg_period = 8'd1;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("apply_ready", cfg_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_leds", leds, 0);
    chk("rst_mid_ready", cfg_ready, 0);
    chk("rst_mid_ready3", rdy3, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_back", cfg_ready, 1);
    acc = 0;
    repeat (40) begin @(negedge clk); acc |= int'(leds); end
    chk("rst_mid_no_update", acc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
